// File: rtl/serial_sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding and default word length.
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

   // Counter width for bit index 0..width-1, never narrower than one bit.
   function automatic int cnt_width(input int width);
      return (width > 1) ? $clog2(width) : 1;
   endfunction

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bout set when the column borrows.
module full_sub_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a-b (LSB first) to a parallel WIDTH-bit result; optional ovf port under SERIAL_SUB_OVF_EN.
// Latency: out_valid rises one cycle after the WIDTH-th accepted bit.
// Backpressure: result held in HOLD with in_ready=0 until out_ready; flush aborts from any state.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             flush,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             out_valid,
   input  logic             out_ready
`ifdef SERIAL_SUB_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CW = cnt_width(WIDTH);

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   cnt;
   logic            br;
   logic [WIDTH-1:0] sreg;
   logic            bout_q;
   logic            out_valid_q;

   logic            accept;
   logic            last_bit;
   logic            release_out;
   logic            cell_d;
   logic            cell_bout;

   assign in_ready    = (state != HOLD);
   assign accept      = in_valid && in_ready;
   assign last_bit    = (cnt == CW'(WIDTH - 1));
   assign release_out = (state == HOLD) && out_valid_q && out_ready;

   full_sub_cell u_cell (
      .a    (a),
      .b    (b),
      .bin  (br),
      .d    (cell_d),
      .bout (cell_bout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = last_bit ? HOLD : SHIFT;
            end
         end
         SHIFT: begin
            if (accept && last_bit) begin
               state_nx = HOLD;
            end
         end
         HOLD: begin
            if (release_out) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
      // Abort beats any same-cycle bit acceptance or output handshake.
      if (flush) begin
         state_nx = IDLE;
      end
   end

   // Bit counter and running borrow; both restart at zero for every word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         br  <= 1'b0;
      end else if (flush) begin
         cnt <= '0;
         br  <= 1'b0;
      end else if (accept) begin
         if (last_bit) begin
            cnt <= '0;
            br  <= 1'b0;
         end else begin
            cnt <= cnt + CW'(1);
            br  <= cell_bout;
         end
      end
   end

   // Difference bits enter at the MSB, so the first bit lands in bit 0 after WIDTH shifts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg <= '0;
      end else if (!flush && accept) begin
         sreg <= {cell_d, sreg[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         bout_q      <= 1'b0;
         out_valid_q <= 1'b0;
      end else if (accept && last_bit) begin
         bout_q      <= cell_bout;
         out_valid_q <= 1'b1;
      end else if (release_out) begin
         out_valid_q <= 1'b0;
      end
   end

`ifdef SERIAL_SUB_OVF_EN
   logic ovf_q;

   // Signed overflow from the sign column: operands differ in sign and the result sign differs from a.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (flush) begin
         ovf_q <= 1'b0;
      end else if (accept && last_bit) begin
         ovf_q <= (a != b) && (cell_d != a);
      end
   end

   assign ovf = ovf_q;
`endif

   assign diff      = sreg;
   assign bout      = bout_q;
   assign out_valid = out_valid_q;

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, word length in bits (legal range 2..64).
REQ-002 SHALL have port clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port a  input  1  minuend serial bit, LSB first.
REQ-005 SHALL have port b  input  1  subtrahend serial bit, LSB first.
REQ-006 SHALL have port in_valid  input  1  a/b pair valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a/b pair this cycle.
REQ-008 SHALL have port flush  input  1  synchronous abort of current word.
REQ-009 SHALL have port diff  output  WIDTH  parallel difference a-b mod 2^WIDTH.
REQ-010 SHALL have port bout  output  1  final borrow (1 when unsigned a < b).
REQ-011 SHALL have port out_valid  output  1  diff/bout valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, HOLD.
REQ-014 SHALL drive in_ready = 1 in IDLE and SHIFT, 0 in HOLD.
REQ-015 SHALL treat a bit as accepted only when in_valid && in_ready on a rising clk edge.
REQ-016 SHALL compute per accepted bit d = a^b^br, br_next = (~a&b)|(~a&br)|(b&br), with br = 0 for the first bit of each word.
REQ-017 SHALL shift d into the MSB of a WIDTH-bit shift register so that after WIDTH bits, bit 0 holds the first-received bit.
REQ-018 SHALL count accepted bits 0..WIDTH-1 in a $clog2(WIDTH)-bit counter; IDLE->SHIFT on the first accepted bit; SHIFT->HOLD on the WIDTH-th accepted bit.
REQ-019 SHALL assert out_valid exactly one cycle after the WIDTH-th bit is accepted, with diff and bout stable while out_valid = 1.
REQ-020 SHALL hold out_valid, diff and bout unchanged in HOLD until out_valid && out_ready, then return to IDLE with out_valid = 0 on the next cycle.
REQ-021 SHALL ignore in_valid gaps in SHIFT (counter and borrow retained).
REQ-022 SHALL, on flush = 1 in any state, go to IDLE next cycle, clear the counter and borrow, and drop out_valid; flush SHALL win over a simultaneous bit acceptance or output handshake (the bit is discarded).
REQ-023 SHALL ignore out_ready outside HOLD.

Reset
REQ-024 SHALL, while rst_n = 0, force state IDLE, counter 0, borrow 0, shift register 0, diff = 0, bout = 0, out_valid = 0, in_ready = 1.
REQ-025 SHALL discard any partial word on reset mid-operation; the first bit after release starts a new word.

Configuration
REQ-026 SHALL, with macro SERIAL_SUB_OVF_EN defined, add port ovf  output  1  signed two's-complement overflow, computed as (a_msb != b_msb) && (d_msb != a_msb), registered and valid with out_valid, reset 0, cleared by flush.
REQ-027 SHALL, without SERIAL_SUB_OVF_EN, have no ovf port and no related logic.

Structure
REQ-028 SHALL place the state enum (IDLE/SHIFT/HOLD) and DEFAULT_WIDTH constant in shared package serial_sub_pkg.
REQ-029 SHALL instantiate one combinational sub-module full_sub_cell (a, b, bin -> d, bout) for the per-bit arithmetic.

Verification (WIDTH = 8)
REQ-030 SHALL cover: a=0x05, b=0x03 serially with in_valid constant -> out_valid one cycle after 8th bit, diff=0x02, bout=0.
REQ-031 SHALL cover: a=0x03, b=0x05 -> diff=0xFE, bout=1; with SERIAL_SUB_OVF_EN, a=0x80, b=0x01 -> diff=0x7F, bout=0, ovf=1.
REQ-032 SHALL cover: out_ready held 0 for 5 cycles after result -> out_valid, diff stable, in_ready=0; out_ready=1 -> IDLE next cycle, next word accepted.
REQ-033 SHALL cover: flush asserted after 4 bits, together with in_valid -> IDLE, then word 0xFF-0x01 -> diff=0xFE, bout=0 (no stale borrow).
REQ-034 SHALL cover: rst_n pulsed low after 3 bits of a word -> all outputs at reset values immediately; next full word 0x10-0x20 -> diff=0xF0, bout=1.
REQ-035 SHALL cover: random in_valid gaps within a word -> result identical to the gap-free case.
